// File: rtl/camera_regs_master.sv
// Avalon-MM master that programs the camera-controller registers, starts capture,
// polls the two line-buffer full flags, clears them and announces each completed line.
module camera_regs_master #(
  parameter int POLL_GAP   = 4,
  parameter int STOP_LINES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_start,
  input  logic        cfg_stop,
  input  logic [15:0] cfg_capture_width,
  input  logic [15:0] cfg_capture_height,
  input  logic [31:0] cfg_buff0,
  input  logic [31:0] cfg_buff1,
  input  logic [15:0] cfg_exposure,
  output logic [4:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest,
  output logic        busy,
  output logic        line_ready,
  output logic        line_buf,
  output logic [15:0] lines_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CFG_WR, S_GAP, S_POLL_RD, S_RD_WAIT, S_CLR_WR, S_STOP_WR
  } state_t;

  localparam logic [15:0] GAP_LAST = (POLL_GAP > 0) ? 16'(POLL_GAP - 1) : 16'd0;
  localparam logic [15:0] STOP_AT  = 16'(STOP_LINES);

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic        sel_q, sel_d;
  logic        stop_q, stop_d;
  logic [15:0] gap_q, gap_d;
  logic        line_ready_q, line_ready_d;
  logic        line_buf_q, line_buf_d;
  logic [15:0] lines_done_q, lines_done_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;
  logic [31:0] buff0_q, buff0_d;
  logic [31:0] buff1_q, buff1_d;
  logic [15:0] exposure_q, exposure_d;
  logic [15:0] lines_inc;
  logic        rdata_unused;

  // Only the flag bit of the status registers carries information.
  assign rdata_unused = ^avm_readdata[31:1];
  assign lines_inc    = lines_done_q + 16'd1;

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    sel_d         = sel_q;
    stop_d        = stop_q;
    gap_d         = gap_q;
    line_ready_d  = 1'b0;
    line_buf_d    = line_buf_q;
    lines_done_d  = lines_done_q;
    width_d       = width_q;
    height_d      = height_q;
    buff0_d       = buff0_q;
    buff1_d       = buff1_q;
    exposure_d    = exposure_q;
    avm_address   = 5'h00;
    avm_read      = 1'b0;
    avm_write     = 1'b0;
    avm_writedata = 32'h0;

    if (state_q != S_IDLE && cfg_stop) stop_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          state_d      = S_CFG_WR;
          idx_d        = 3'd0;
          sel_d        = 1'b0;
          stop_d       = 1'b0;
          lines_done_d = 16'd0;
          width_d      = cfg_capture_width;
          height_d     = cfg_capture_height;
          buff0_d      = cfg_buff0;
          buff1_d      = cfg_buff1;
          exposure_d   = cfg_exposure;
        end
      end
      S_CFG_WR: begin
        avm_write = 1'b1;
        case (idx_q)
          3'd0: begin avm_address = 5'h01; avm_writedata = {16'h0, width_q};    end
          3'd1: begin avm_address = 5'h02; avm_writedata = {16'h0, height_q};   end
          3'd2: begin avm_address = 5'h03; avm_writedata = buff0_q;             end
          3'd3: begin avm_address = 5'h04; avm_writedata = buff1_q;             end
          3'd4: begin avm_address = 5'h11; avm_writedata = {16'h0, exposure_q}; end
          default: begin avm_address = 5'h00; avm_writedata = 32'h1;           end
        endcase
        if (!avm_waitrequest) begin
          if (idx_q == 3'd5) begin
            state_d = S_GAP;
            sel_d   = 1'b0;
            gap_d   = 16'd0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q >= GAP_LAST) state_d = stop_q ? S_STOP_WR : S_POLL_RD;
        else                   gap_d   = gap_q + 16'd1;
      end
      S_POLL_RD: begin
        avm_read    = 1'b1;
        avm_address = sel_q ? 5'h06 : 5'h05;
        if (!avm_waitrequest) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (avm_readdatavalid) begin
          if (avm_readdata[0]) begin
            state_d = S_CLR_WR;
          end else begin
            sel_d   = ~sel_q;
            gap_d   = 16'd0;
            state_d = S_GAP;
          end
        end
      end
      S_CLR_WR: begin
        avm_write   = 1'b1;
        avm_address = sel_q ? 5'h06 : 5'h05;
        if (!avm_waitrequest) begin
          line_ready_d = 1'b1;
          line_buf_d   = sel_q;
          lines_done_d = lines_inc;
          sel_d        = ~sel_q;
          gap_d        = 16'd0;
          state_d      = S_GAP;
          if (STOP_LINES != 0 && lines_inc == STOP_AT) stop_d = 1'b1;
        end
      end
      S_STOP_WR: begin
        avm_write = 1'b1;
        if (!avm_waitrequest) begin
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 3'd0;
      sel_q        <= 1'b0;
      stop_q       <= 1'b0;
      gap_q        <= 16'd0;
      line_ready_q <= 1'b0;
      line_buf_q   <= 1'b0;
      lines_done_q <= 16'd0;
      width_q      <= 16'd0;
      height_q     <= 16'd0;
      buff0_q      <= 32'd0;
      buff1_q      <= 32'd0;
      exposure_q   <= 16'd0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      sel_q        <= sel_d;
      stop_q       <= stop_d;
      gap_q        <= gap_d;
      line_ready_q <= line_ready_d;
      line_buf_q   <= line_buf_d;
      lines_done_q <= lines_done_d;
      width_q      <= width_d;
      height_q     <= height_d;
      buff0_q      <= buff0_d;
      buff1_q      <= buff1_d;
      exposure_q   <= exposure_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign line_ready = line_ready_q;
  assign line_buf   = line_buf_q;
  assign lines_done = lines_done_q;

endmodule
